// File: rtl/weight_bit_sequencer.sv
// weight_bit_sequencer: feeds a bit-serial MAC one magnitude bit-column per cycle, MSB first, then one flush cycle.
// Define WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN to skip bit-columns that are zero in every lane.
module weight_bit_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 8,
    parameter int NUM_COLS   = DATA_WIDTH - 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic signed [DATA_WIDTH-1:0]       weight [VEC_LENGTH],
    input  logic                               ld_prev,
    output logic                               en,
    output logic                               load_accum,
    output logic        [VEC_LENGTH-1:0]       sign,
    output logic        [VEC_LENGTH-1:0]       w_bit,
    output logic        [$clog2(NUM_COLS)-1:0] column_idx,
    output logic                               group_done
);
    localparam int CW = $clog2(NUM_COLS);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [NUM_COLS-1:0]   mag_q [VEC_LENGTH];
    logic [NUM_COLS-1:0]   mag_d [VEC_LENGTH];
    logic [NUM_COLS-1:0]   new_mag [VEC_LENGTH];
    logic [VEC_LENGTH-1:0] sign_q, sign_d, new_sign;
    logic                  ld_q, ld_d, first_q, first_d, accept;
    logic [DATA_WIDTH-1:0] abs_w;

    // -128 has no positive counterpart, so it saturates to the largest magnitude
    always_comb begin
        abs_w = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            new_sign[j] = weight[j][DATA_WIDTH-1];
            abs_w       = new_sign[j] ? DATA_WIDTH'(-weight[j]) : weight[j];
            new_mag[j]  = abs_w[DATA_WIDTH-1] ? '1 : abs_w[NUM_COLS-1:0];
        end
    end

`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
    logic [NUM_COLS-1:0] nz_q, nz_d, new_nz;
    logic                start_hit, next_hit;
    logic [CW-1:0]       start_col, next_col;

    always_comb begin
        new_nz    = '0;
        start_hit = 1'b0;
        start_col = '0;
        next_hit  = 1'b0;
        next_col  = '0;
        for (int j = 0; j < VEC_LENGTH; j++) new_nz = new_nz | new_mag[j];
        for (int c = 0; c < NUM_COLS; c++) begin
            if (new_nz[c]) begin
                start_hit = 1'b1;
                start_col = CW'(c);
            end
            if (nz_q[c] && CW'(c) < col_q) begin
                next_hit = 1'b1;
                next_col = CW'(c);
            end
        end
    end
`endif

    always_comb begin
        accept  = w_valid && (state_q != ISSUE);
        state_d = state_q;
        col_d   = col_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        ld_d    = ld_q;
        first_d = first_q;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
        nz_d    = nz_q;
`endif
        if (state_q == ISSUE) begin
            first_d = 1'b0;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
            state_d = next_hit ? ISSUE : FLUSH;
            col_d   = next_hit ? next_col : col_q;
`else
            state_d = (col_q == '0) ? FLUSH : ISSUE;
            col_d   = (col_q == '0) ? col_q : col_q - CW'(1);
`endif
        end else if (state_q == FLUSH) begin
            state_d = IDLE;
        end
        if (accept) begin
            mag_d   = new_mag;
            sign_d  = new_sign;
            ld_d    = ld_prev;
            first_d = 1'b1;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
            nz_d    = new_nz;
            state_d = start_hit ? ISSUE : FLUSH;
            col_d   = start_hit ? start_col : col_q;
`else
            state_d = ISSUE;
            col_d   = CW'(NUM_COLS - 1);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            sign_q  <= '0;
            ld_q    <= 1'b0;
            first_q <= 1'b0;
            for (int j = 0; j < VEC_LENGTH; j++) mag_q[j] <= '0;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
            nz_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            sign_q  <= sign_d;
            ld_q    <= ld_d;
            first_q <= first_d;
            mag_q   <= mag_d;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
            nz_q    <= nz_d;
`endif
        end
    end

    always_comb begin
        for (int j = 0; j < VEC_LENGTH; j++) w_bit[j] = (state_q == ISSUE) && mag_q[j][col_q];
    end

    assign en         = state_q != IDLE;
    assign w_ready    = state_q != ISSUE;
    assign group_done = state_q == FLUSH;
    assign load_accum = en && ld_q && first_q;
    assign sign       = sign_q;
    assign column_idx = col_q;
endmodule

// File: tb/tb_weight_bit_sequencer.sv
// tb_weight_bit_sequencer: directed and random groups checked against a column-list model of the sequencer.
module tb_weight_bit_sequencer;
    typedef logic signed [7:0] grp_t [8];

    logic       clk = 1'b0;
    logic       reset, w_valid, ld_prev;
    grp_t       weight;
    logic       w_ready, en, load_accum, group_done;
    logic [7:0] sign, w_bit;
    logic [2:0] column_idx;

    int         total = 0;
    int         bad = 0;
    int         en_cnt = 0;
    logic [7:0] last_sign = '0;

    weight_bit_sequencer dut (
        .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .weight(weight),
        .ld_prev(ld_prev), .en(en), .load_accum(load_accum), .sign(sign), .w_bit(w_bit),
        .column_idx(column_idx), .group_done(group_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: per-lane magnitudes by plain arithmetic, then the list of columns the group occupies.
    task automatic check_group(input grp_t g, input bit ld);
        int         m [8];
        int         cols [$];
        logic [7:0] sg, eb;
        bit         any;
        for (int j = 0; j < 8; j++) begin
            m[j]  = int'(g[j]);
            sg[j] = m[j] < 0;
            if (m[j] < 0) m[j] = -m[j];
            if (m[j] > 127) m[j] = 127;
        end
        for (int c = 6; c >= 0; c--) begin
            any = 1'b0;
            for (int j = 0; j < 8; j++) any |= ((m[j] >> c) & 1) != 0;
`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
            if (any) cols.push_back(c);
`else
            cols.push_back(c);
`endif
        end
        for (int i = 0; i < cols.size(); i++) begin
            for (int j = 0; j < 8; j++) eb[j] = ((m[j] >> cols[i]) & 1) != 0;
            if (en === 1'b1) en_cnt++;
            chk("issue_en", en, 1);
            chk("issue_col", column_idx, cols[i]);
            chk("issue_wbit", w_bit, eb);
            chk("issue_sign", sign, sg);
            chk("issue_ld", load_accum, ld && i == 0);
            chk("issue_done", group_done, 0);
            chk("issue_rdy", w_ready, 0);
            step();
        end
        if (en === 1'b1) en_cnt++;
        chk("flush_en", en, 1);
        chk("flush_done", group_done, 1);
        chk("flush_wbit", w_bit, 0);
        chk("flush_ld", load_accum, ld && cols.size() == 0);
        chk("flush_rdy", w_ready, 1);
        last_sign = sg;
        step();
    endtask

    task automatic check_idle();
        chk("idle_en", en, 0);
        chk("idle_done", group_done, 0);
        chk("idle_wbit", w_bit, 0);
        chk("idle_ld", load_accum, 0);
        chk("idle_rdy", w_ready, 1);
        chk("idle_sign", sign, last_sign);
`ifndef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
        chk("idle_col", column_idx, 0);
`endif
    endtask

    task automatic send(input grp_t g, input bit ld);
        weight  = g;
        ld_prev = ld;
        w_valid = 1'b1;
        chk("accept_rdy", w_ready, 1);
        step();
        w_valid = 1'b0;
    endtask

    task automatic rand_grp(output grp_t g);
        int kind;
        kind = $urandom_range(0, 3);
        for (int j = 0; j < 8; j++) begin
            case ($urandom_range(0, 5))
                0:       g[j] = -8'sd128;
                1:       g[j] = 8'sd0;
                2:       g[j] = 8'($urandom_range(0, 7));
                default: g[j] = 8'($urandom);
            endcase
            if (kind == 0) g[j] = 8'($urandom_range(0, 5));
            if (kind == 1 && $urandom_range(0, 1) == 1) g[j] = 8'sd0;
        end
    endtask

    initial begin
        grp_t g, h;
        bit   la, lb;
        reset   = 1'b0;
        w_valid = 1'b0;
        ld_prev = 1'b0;
        for (int j = 0; j < 8; j++) weight[j] = 8'sd0;
        step();
        step();
        chk("rst_en", en, 0);
        chk("rst_ld", load_accum, 0);
        chk("rst_rdy", w_ready, 1);
        chk("rst_done", group_done, 0);
        chk("rst_wbit", w_bit, 0);
        chk("rst_sign", sign, 0);
        chk("rst_col", column_idx, 0);
        reset = 1'b1;
        step();

        g = '{8'sd1, -8'sd1, 8'sd2, -8'sd2, 8'sd64, -8'sd64, 8'sd127, 8'sd0};
        send(g, 1'b0);
        chk("basic_c6_col", column_idx, 6);
        chk("basic_c6_wbit", w_bit, 8'b0111_0000);
        chk("basic_sign", sign, 8'b0010_1010);
        check_group(g, 1'b0);
        check_idle();

        g = '{-8'sd128, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        send(g, 1'b1);
        chk("sat_sign0", sign[0], 1);
        chk("sat_wbit0", w_bit[0], 1);
        chk("sat_ld", load_accum, 1);
        check_group(g, 1'b1);
        check_idle();

        rand_grp(g);
        rand_grp(h);
        weight  = g;
        ld_prev = 1'b1;
        w_valid = 1'b1;
        en_cnt  = 0;
        step();
        weight  = h;
        ld_prev = 1'b0;
        check_group(g, 1'b1);
        w_valid = 1'b0;
        check_group(h, 1'b0);
`ifndef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
        chk("b2b_en_cycles", en_cnt, 16);
`endif
        check_idle();

`ifdef WEIGHT_BIT_SEQUENCER_ZERO_COL_SKIP_EN
        g = '{8'sd5, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        send(g, 1'b0);
        chk("skip_first_col", column_idx, 2);
        check_group(g, 1'b0);
        check_idle();
        for (int j = 0; j < 8; j++) g[j] = 8'sd0;
        send(g, 1'b1);
        chk("skip_zero_ld", load_accum, 1);
        chk("skip_zero_done", group_done, 1);
        check_group(g, 1'b1);
        check_idle();
`endif

        for (int k = 0; k < 30; k++) begin
            rand_grp(g);
            la = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                rand_grp(h);
                lb      = 1'($urandom_range(0, 1));
                weight  = g;
                ld_prev = la;
                w_valid = 1'b1;
                step();
                weight  = h;
                ld_prev = lb;
                check_group(g, la);
                w_valid = 1'b0;
                check_group(h, lb);
            end else begin
                send(g, la);
                check_group(g, la);
            end
            check_idle();
            if ($urandom_range(0, 1) == 1) step();
        end

        for (int j = 0; j < 8; j++) g[j] = 8'sd127;
        send(g, 1'b0);
        step();
        step();
        step();
        chk("mid_col3", column_idx, 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_en", en, 0);
        chk("mid_rst_rdy", w_ready, 1);
        chk("mid_rst_wbit", w_bit, 0);
        chk("mid_rst_done", group_done, 0);
        #10 reset = 1'b1;
        step();
        last_sign = '0;
        check_idle();
        rand_grp(g);
        send(g, 1'b1);
        check_group(g, 1'b1);
        check_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
